// File: rtl/bypass_scoreboard_unit.sv
// Operand bypass network with a per-register pending-writer scoreboard.
// Operands are held in a registered issue stage behind a valid/ready handshake.
module bypass_scoreboard_unit #(
  parameter int XLEN        = 32,
  parameter int STAGES      = 3,
  parameter int OPERANDS    = 2,
  parameter int MAX_PENDING = 3
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       issue_valid_i,
  input  logic [4:0]                 issue_reg_dest_i,
  input  logic [OPERANDS*5-1:0]      reg_src_i,
  input  logic [OPERANDS*XLEN-1:0]   reg_fetch_operand_i,
  input  logic [STAGES*XLEN-1:0]     stage_operand_i,
  input  logic [STAGES*5-1:0]        stage_reg_dest_i,
  input  logic [STAGES-1:0]          stage_valid_i,
  input  logic                       retire_valid_i,
  input  logic [4:0]                 retire_reg_dest_i,
  input  logic                       exec_ready_i,
  output logic                       stall_o,
  output logic                       operand_valid_o,
  output logic [OPERANDS*XLEN-1:0]   operand_o,
  output logic [OPERANDS-1:0]        bypassed_o
);

  localparam int CW = $clog2(MAX_PENDING + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_PENDING);

  logic [31:0][CW-1:0]       count_q, count_d;
  logic                      operand_valid_q, operand_valid_d;
  logic [OPERANDS*XLEN-1:0]  operand_q, operand_d;
  logic [OPERANDS-1:0]       bypassed_q, bypassed_d;

  logic [OPERANDS*XLEN-1:0]  sel_operand;
  logic [OPERANDS-1:0]       sel_bypassed;
  logic [OPERANDS-1:0]       hazard;
  logic                      dest_full;
  logic                      accept;
  logic                      retire_underflow;

  // Every in-flight writer must be visible in a forwarding stage before we bypass;
  // otherwise the youngest value may not have been produced yet.
  always_comb begin
    logic [4:0]      src;
    logic [7:0]      pop;
    logic [XLEN-1:0] fwd;
    sel_operand  = '0;
    sel_bypassed = '0;
    hazard       = '0;
    src          = '0;
    pop          = '0;
    fwd          = '0;
    for (int k = 0; k < OPERANDS; k++) begin
      src = reg_src_i[5*k +: 5];
      pop = '0;
      fwd = '0;
      for (int s = STAGES - 1; s >= 0; s--) begin
        if (stage_valid_i[s] && (stage_reg_dest_i[5*s +: 5] == src)) begin
          pop = pop + 8'd1;
          fwd = stage_operand_i[XLEN*s +: XLEN];
        end
      end
      if (src == 5'd0) begin
        sel_operand[XLEN*k +: XLEN] = '0;
      end else if (count_q[src] == '0) begin
        sel_operand[XLEN*k +: XLEN] = reg_fetch_operand_i[XLEN*k +: XLEN];
      end else if (pop == 8'(count_q[src])) begin
        sel_operand[XLEN*k +: XLEN] = fwd;
        sel_bypassed[k]             = 1'b1;
      end else begin
        hazard[k] = 1'b1;
      end
    end
  end

  assign dest_full = (issue_reg_dest_i != 5'd0) && (count_q[issue_reg_dest_i] == MAX_CNT);
  assign stall_o   = issue_valid_i &&
                     ((|hazard) || dest_full || (operand_valid_q && !exec_ready_i));
  assign accept    = issue_valid_i && !stall_o;

  always_comb begin
    operand_valid_d = operand_valid_q;
    operand_d       = operand_q;
    bypassed_d      = bypassed_q;
    if (accept) begin
      operand_valid_d = 1'b1;
      operand_d       = sel_operand;
      bypassed_d      = sel_bypassed;
    end else if (operand_valid_q && exec_ready_i) begin
      operand_valid_d = 1'b0;
    end
  end

  assign count_d[0] = '0;
  for (genvar gi = 1; gi < 32; gi++) begin : g_count
    logic inc, dec;
    assign inc = accept && (issue_reg_dest_i == 5'(gi));
    assign dec = retire_valid_i && (retire_reg_dest_i == 5'(gi)) && (count_q[gi] != '0);
    assign count_d[gi] = count_q[gi] + CW'(inc) - CW'(dec);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q         <= '0;
      operand_valid_q <= 1'b0;
      operand_q       <= '0;
      bypassed_q      <= '0;
    end else begin
      count_q         <= count_d;
      operand_valid_q <= operand_valid_d;
      operand_q       <= operand_d;
      bypassed_q      <= bypassed_d;
    end
  end

  assign operand_valid_o = operand_valid_q;
  assign operand_o       = operand_q;
  assign bypassed_o      = bypassed_q;

  assign retire_underflow = retire_valid_i && (retire_reg_dest_i != 5'd0) &&
                            (count_q[retire_reg_dest_i] == '0);

  a_no_retire_underflow: assert property (@(posedge clk_i) disable iff (rst_i) !retire_underflow);

endmodule

// File: tb/tb_bypass_scoreboard_unit.sv
// Table-driven bench for bypass_scoreboard_unit with a queue of expected issue results.
module tb_bypass_scoreboard_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        issue_valid_i;
  logic [4:0]  issue_reg_dest_i;
  logic [9:0]  reg_src_i;
  logic [63:0] reg_fetch_operand_i;
  logic [95:0] stage_operand_i;
  logic [14:0] stage_reg_dest_i;
  logic [2:0]  stage_valid_i;
  logic        retire_valid_i;
  logic [4:0]  retire_reg_dest_i;
  logic        exec_ready_i;
  logic        stall_o;
  logic        operand_valid_o;
  logic [63:0] operand_o;
  logic [1:0]  bypassed_o;

  bypass_scoreboard_unit dut (
    .clk_i               (clk_i),
    .rst_i               (rst_i),
    .issue_valid_i       (issue_valid_i),
    .issue_reg_dest_i    (issue_reg_dest_i),
    .reg_src_i           (reg_src_i),
    .reg_fetch_operand_i (reg_fetch_operand_i),
    .stage_operand_i     (stage_operand_i),
    .stage_reg_dest_i    (stage_reg_dest_i),
    .stage_valid_i       (stage_valid_i),
    .retire_valid_i      (retire_valid_i),
    .retire_reg_dest_i   (retire_reg_dest_i),
    .exec_ready_i        (exec_ready_i),
    .stall_o             (stall_o),
    .operand_valid_o     (operand_valid_o),
    .operand_o           (operand_o),
    .bypassed_o          (bypassed_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic        iv;
    logic [4:0]  dest;
    logic [9:0]  src;     // {src1, src0}
    logic [63:0] rf;      // {rf1, rf0}
    logic [2:0]  sv;
    logic [14:0] sd;      // {sd2, sd1, sd0}
    logic [95:0] so;      // {so2, so1, so0}
    logic        rv;
    logic [4:0]  rd;
    logic        rdy;
    logic        e_stall;
    logic        e_valid;
    logic [63:0] e_op;    // {op1, op0}, meaningful on accepted rows
    logic [1:0]  e_byp;
  } vec_t;

  vec_t        tbl[$];
  logic [65:0] sb_q[$];
  logic [65:0] held_exp;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input int n, input vec_t v);
    logic [65:0] exp;
    logic        accepted;
    issue_valid_i       = v.iv;
    issue_reg_dest_i    = v.dest;
    reg_src_i           = v.src;
    reg_fetch_operand_i = v.rf;
    stage_valid_i       = v.sv;
    stage_reg_dest_i    = v.sd;
    stage_operand_i     = v.so;
    retire_valid_i      = v.rv;
    retire_reg_dest_i   = v.rd;
    exec_ready_i        = v.rdy;
    #1;
    check($sformatf("stall[%0d]", n), 96'(stall_o), 96'(v.e_stall));
    accepted = v.iv && !v.e_stall;
    if (accepted) sb_q.push_back({v.e_byp, v.e_op});
    @(negedge clk_i);
    $display("txn %0d: stall=%0b valid=%0b op=%h byp=%b", n, stall_o, operand_valid_o, operand_o, bypassed_o);
    check($sformatf("valid[%0d]", n), 96'(operand_valid_o), 96'(v.e_valid));
    if (accepted) begin
      exp      = sb_q.pop_front();
      held_exp = exp;
      check($sformatf("operand[%0d]", n), 96'(operand_o), 96'(exp[63:0]));
      check($sformatf("bypassed[%0d]", n), 96'(bypassed_o), 96'(exp[65:64]));
    end else if (v.e_valid) begin
      check($sformatf("held_operand[%0d]", n), 96'(operand_o), 96'(held_exp[63:0]));
      check($sformatf("held_bypassed[%0d]", n), 96'(bypassed_o), 96'(held_exp[65:64]));
    end
  endtask

  initial begin
    // iv dest src rf sv sd so rv rd rdy | e_stall e_valid e_op e_byp
    tbl.push_back('{1'b1, 5'd0, {5'd2,5'd1}, {32'h22,32'h11}, 3'b000, 15'd0, 96'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, {32'h22,32'h11}, 2'b00});
    tbl.push_back('{1'b1, 5'd5, {5'd0,5'd0}, {32'h33,32'h44}, 3'b000, 15'd0, 96'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 64'd0, 2'b00});
    tbl.push_back('{1'b1, 5'd0, {5'd0,5'd5}, 64'd0, 3'b000, 15'd0, 96'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 64'd0, 2'b00});
    tbl.push_back('{1'b1, 5'd0, {5'd0,5'd5}, 64'd0, 3'b010, {5'd0,5'd5,5'd0}, {32'h0,32'hABCD,32'h0}, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, {32'h0,32'hABCD}, 2'b01});
    tbl.push_back('{1'b0, 5'd0, 10'd0, 64'd0, 3'b000, 15'd0, 96'd0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 64'd0, 2'b00});
    tbl.push_back('{1'b1, 5'd7, 10'd0, 64'd0, 3'b000, 15'd0, 96'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 64'd0, 2'b00});
    tbl.push_back('{1'b1, 5'd7, 10'd0, 64'd0, 3'b000, 15'd0, 96'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 64'd0, 2'b00});
    tbl.push_back('{1'b1, 5'd0, {5'd0,5'd7}, 64'd0, 3'b101, {5'd7,5'd0,5'd7}, {32'h2,32'h0,32'h1}, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, {32'h0,32'h1}, 2'b01});
    tbl.push_back('{1'b1, 5'd0, {5'd7,5'd0}, 64'd0, 3'b100, {5'd7,5'd0,5'd0}, {32'h2,32'h0,32'h0}, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 64'd0, 2'b00});
    tbl.push_back('{1'b1, 5'd0, {5'd7,5'd7}, 64'd0, 3'b101, {5'd7,5'd0,5'd7}, {32'h2,32'h0,32'h1}, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, {32'h1,32'h1}, 2'b11});
    tbl.push_back('{1'b0, 5'd0, 10'd0, 64'd0, 3'b000, 15'd0, 96'd0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 64'd0, 2'b00});
    tbl.push_back('{1'b0, 5'd0, 10'd0, 64'd0, 3'b000, 15'd0, 96'd0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 64'd0, 2'b00});
    tbl.push_back('{1'b1, 5'd0, {5'd0,5'd7}, {32'h0,32'h55}, 3'b001, {5'd0,5'd0,5'd7}, {32'h0,32'h0,32'h99}, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, {32'h0,32'h55}, 2'b00});
    for (int i = 0; i < 3; i++)
      tbl.push_back('{1'b1, 5'd9, 10'd0, 64'd0, 3'b000, 15'd0, 96'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 64'd0, 2'b00});
    tbl.push_back('{1'b1, 5'd9, 10'd0, 64'd0, 3'b000, 15'd0, 96'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 64'd0, 2'b00});
    tbl.push_back('{1'b1, 5'd9, 10'd0, 64'd0, 3'b000, 15'd0, 96'd0, 1'b1, 5'd9, 1'b1, 1'b1, 1'b0, 64'd0, 2'b00});
    tbl.push_back('{1'b1, 5'd9, 10'd0, 64'd0, 3'b000, 15'd0, 96'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 64'd0, 2'b00});
    tbl.push_back('{1'b1, 5'd9, 10'd0, 64'd0, 3'b000, 15'd0, 96'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 64'd0, 2'b00});
    tbl.push_back('{1'b0, 5'd0, 10'd0, 64'd0, 3'b000, 15'd0, 96'd0, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 64'd0, 2'b00});
    tbl.push_back('{1'b1, 5'd9, 10'd0, 64'd0, 3'b000, 15'd0, 96'd0, 1'b1, 5'd9, 1'b1, 1'b0, 1'b1, 64'd0, 2'b00});
    tbl.push_back('{1'b1, 5'd9, 10'd0, 64'd0, 3'b000, 15'd0, 96'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 64'd0, 2'b00});
    tbl.push_back('{1'b1, 5'd9, 10'd0, 64'd0, 3'b000, 15'd0, 96'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 64'd0, 2'b00});
    tbl.push_back('{1'b1, 5'd0, {5'd2,5'd1}, {32'hBB,32'hAA}, 3'b000, 15'd0, 96'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, {32'hBB,32'hAA}, 2'b00});
    for (int i = 0; i < 4; i++)
      tbl.push_back('{1'b1, 5'd0, {5'd2,5'd1}, {32'hDD,32'hCC}, 3'b000, 15'd0, 96'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 64'd0, 2'b00});
    tbl.push_back('{1'b1, 5'd0, {5'd2,5'd1}, {32'hDD,32'hCC}, 3'b000, 15'd0, 96'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, {32'hDD,32'hCC}, 2'b00});
    tbl.push_back('{1'b0, 5'd0, {5'd0,5'd9}, 64'd0, 3'b000, 15'd0, 96'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 64'd0, 2'b00});

    rst_i               = 1'b1;
    issue_valid_i       = 1'b0;
    issue_reg_dest_i    = '0;
    reg_src_i           = '0;
    reg_fetch_operand_i = '0;
    stage_operand_i     = '0;
    stage_reg_dest_i    = '0;
    stage_valid_i       = '0;
    retire_valid_i      = 1'b0;
    retire_reg_dest_i   = '0;
    exec_ready_i        = 1'b1;
    held_exp            = '0;
    #2;
    check("reset_valid", 96'(operand_valid_o), 96'(1'b0));
    check("reset_operand", 96'(operand_o), 96'd0);
    check("reset_bypassed", 96'(bypassed_o), 96'd0);
    check("reset_stall", 96'(stall_o), 96'(1'b0));
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;

    for (int i = 0; i < tbl.size(); i++) step(i, tbl[i]);

    // Two writers to x3 in flight, then a hazard stall held by a busy consumer.
    step(100, '{1'b1, 5'd3, 10'd0, 64'd0, 3'b000, 15'd0, 96'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 64'd0, 2'b00});
    step(101, '{1'b1, 5'd3, {5'd2,5'd1}, {32'h2222,32'h1111}, 3'b000, 15'd0, 96'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, {32'h2222,32'h1111}, 2'b00});
    step(102, '{1'b1, 5'd0, {5'd0,5'd3}, 64'd0, 3'b000, 15'd0, 96'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 64'd0, 2'b00});
    #2;
    rst_i = 1'b1;
    #1;
    check("midrst_valid", 96'(operand_valid_o), 96'(1'b0));
    check("midrst_operand", 96'(operand_o), 96'd0);
    check("midrst_bypassed", 96'(bypassed_o), 96'd0);
    check("midrst_stall", 96'(stall_o), 96'(1'b0));
    @(negedge clk_i);
    rst_i    = 1'b0;
    held_exp = '0;
    // x3 and x9 counts cleared by reset; x0 source ignores a valid stage aimed at x0.
    step(103, '{1'b1, 5'd9, {5'd0,5'd3}, {32'h7777,32'h3333}, 3'b001, 15'd0, {32'h0,32'h0,32'hFFFF}, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, {32'h0,32'h3333}, 2'b00});
    step(104, '{1'b1, 5'd0, {5'd9,5'd0}, 64'd0, 3'b000, 15'd0, 96'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 64'd0, 2'b00});

    check("scoreboard_empty", 96'(sb_q.size()), 96'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bypass_scoreboard_unit.md
Name: bypass_scoreboard_unit

Overview:
- Parametrised operand-bypass network with a pending-write scoreboard and a registered issue stage.
- Sits between register fetch and the execution units.
- Tracks in-flight writers per architectural register and selects each source operand from the youngest valid forwarding stage or the register file.
- Stalls issue when a needed result has not been produced yet, and presents operands downstream through a valid/ready handshake.

Parameters:
XLEN, 32, operand width
STAGES, 3, number of forwarding stages; index 0 is the youngest (highest priority)
OPERANDS, 2, number of source operands per instruction
MAX_PENDING, 3, maximum in-flight writers per register; counter width CW = $clog2(MAX_PENDING+1)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
issue_valid_i  in  1  instruction presented for issue
issue_reg_dest_i  in  5  destination register of the issuing instruction (x0 = none)
reg_src_i  in  OPERANDS*5  source register indices, operand k at [5k+:5]
reg_fetch_operand_i  in  OPERANDS*XLEN  register-file read values
stage_operand_i  in  STAGES*XLEN  forwarding stage results
stage_reg_dest_i  in  STAGES*5  forwarding stage destination registers
stage_valid_i  in  STAGES  forwarding stage result valid
retire_valid_i  in  1  a result is written to the register file this cycle
retire_reg_dest_i  in  5  register being written
exec_ready_i  in  1  downstream accepts operands
stall_o  out  1  issue not accepted this cycle
operand_valid_o  out  1  registered operands valid
operand_o  out  OPERANDS*XLEN  registered selected operands
bypassed_o  out  OPERANDS  operand k came from a forwarding stage

Behaviour:
- Reset (async, rst_i=1): all scoreboard counters = 0; operand_valid_o = 0; operand_o = 0; bypassed_o = 0. Reset mid-operation discards the held output and all pending counts immediately.
- stall_o is combinational and asserts only when issue_valid_i = 1 and any of the following holds:
  - an operand hazard exists;
  - the counter of a non-zero issue_reg_dest_i equals MAX_PENDING;
  - operand_valid_o = 1 and exec_ready_i = 0.
- Operand selection for operand k, with src = reg_src_i[k]:
  - If src = 0: value 0, never a hazard, bypassed = 0.
  - Otherwise, match[s] = stage_valid_i[s] and stage_reg_dest_i[s] == src.
  - If count[src] = 0: take reg_fetch_operand_i[k].
  - Otherwise, if popcount(match) == count[src]: take the value from the lowest-index matching stage, bypassed = 1.
  - Otherwise (some writer has not produced its result): hazard.
- Accept = issue_valid_i and not stall_o. On accept, at the next clk_i edge:
  - operand_o and bypassed_o load the selected values;
  - operand_valid_o becomes 1;
  - count[issue_reg_dest_i] increments if the destination is non-zero.
- Latency is one cycle from accept to operand_valid_o.
- Output handshake:
  - If operand_valid_o = 1, exec_ready_i = 1 and there is no accept, operand_valid_o clears.
  - If operand_valid_o = 1 and exec_ready_i = 0, outputs hold unchanged.
  - Accept in the same cycle as exec_ready_i = 1 gives back-to-back issue: outputs reload and operand_valid_o stays 1.
- Retire: retire_valid_i with a non-zero destination decrements count[retire_reg_dest_i].
  - Retire of a register whose count is 0 is ignored (count stays 0) and flagged by a simulation assertion.
  - Retire to x0 is ignored.
- Simultaneous accept-increment and retire-decrement on the same register: count unchanged.
- Counters never exceed MAX_PENDING; saturation is prevented by the stall condition, never by wrap-around.
- Operand selection, stall decision and retire update in the same cycle all use the pre-edge count.
- The forwarding stages must hold every produced-but-not-retired result; this is a guaranteed system invariant.

Test Plan:
- Reset, then issue with srcs x1/x2, all counts 0, regfile values 0x11/0x22 -> stall_o=0; next cycle operand_valid_o=1, operand_o={0x22,0x11}, bypassed_o=00.
- Issue dest x5; next issue reads src x5 with stage_valid_i=000 -> stall_o=1. Then stage1 becomes valid with dest x5, value 0xABCD -> stall_o=0; operand_o=0xABCD, bypassed=1.
- Two writers to x7 in flight (count 2); stage0=0x1 and stage2=0x2 both valid with dest x7 -> operand 0x1 (youngest wins). With only stage2 valid -> stall_o=1.
- Three accepted issues to x9 (MAX_PENDING=3) -> fourth issue to x9 stalls. Retire x9 in the same cycle as that fourth issue -> still stalled (pre-edge count); next cycle it issues and count returns to 3.
- operand_valid_o=1, exec_ready_i=0 for 4 cycles -> outputs stable and stall_o=1 during that time. Then exec_ready_i=1 with a new issue -> back-to-back reload, operand_valid_o stays 1.
- Assert rst_i mid-stall with count[x3]=2 -> outputs zero immediately and the count clears. Source x0 with stage_reg_dest=0 valid -> operand 0, no bypass.
